// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM encoding and bus layouts for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int unsigned EsToMsBusWd  = 136;
   localparam int unsigned MsToWsBusWd  = 126;
   localparam int unsigned StallBusWd   = 10;
   localparam int unsigned ForwardBusWd = 33;

   // Bit positions inside the one-hot inst_load field {lw,lb,lbu,lh,lhu,lwl,lwr}.
   localparam int unsigned LdLw  = 6;
   localparam int unsigned LdLb  = 5;
   localparam int unsigned LdLbu = 4;
   localparam int unsigned LdLh  = 3;
   localparam int unsigned LdLhu = 2;
   localparam int unsigned LdLwl = 1;
   localparam int unsigned LdLwr = 0;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StHave = 2'b10
   } resp_state_e;

   typedef struct packed {
      logic [31:0] badvaddr;
      logic        bd;
      logic        exc;
      logic [7:0]  exc_type;
      logic        eret_flush;
      logic        cp0_wen;
      logic        res_from_cp0;
      logic [7:0]  cp0_addr;
      logic        res_from_mem;
      logic [6:0]  inst_load;
      logic [4:0]  ld_extd_op;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        bd;
      logic        exc;
      logic [7:0]  exc_type;
      logic [31:0] badvaddr;
      logic        eret_flush;
      logic        cp0_wen;
      logic        res_from_cp0;
      logic [7:0]  cp0_addr;
      logic [3:0]  rf_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side signals of the MEM stage: EXE input bus, WB output bus, data SRAM
// response channel and the stall/forward/exception side buses.
interface mem_stage_if
   import mem_stage_pkg::*;
#(
   parameter int unsigned ES_TO_MS_BUS_WD = EsToMsBusWd,
   parameter int unsigned MS_TO_WS_BUS_WD = MsToWsBusWd
);

   logic                        flush;
   logic                        ws_allowin;
   logic                        ms_allowin;
   logic                        es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus;
   logic                        data_sram_data_ok;
   logic [31:0]                 data_sram_rdata;
   logic                        ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus;
   logic [StallBusWd-1:0]       stall_ms_bus;
   logic [ForwardBusWd-1:0]     forward_ms_bus;
   logic                        ms_exc_eret;

   // The MEM stage itself.
   modport master (
      input  flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
      input  data_sram_data_ok, data_sram_rdata,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
      output stall_ms_bus, forward_ms_bus, ms_exc_eret
   );

   // The surrounding pipeline (EXE, WB, data SRAM).
   modport slave (
      output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus,
      output data_sram_data_ok, data_sram_rdata,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
      input  stall_ms_bus, forward_ms_bus, ms_exc_eret
   );

endinterface

// File: rtl/mem_stage_ld_select.sv
// Load data extraction: picks and extends the addressed bytes of a little-endian
// read word and produces the matching per-byte register write strobes.
module mem_stage_ld_select
   import mem_stage_pkg::*;
(
   input  logic [6:0]  inst_load,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] result,
   output logic [3:0]  rf_we
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Decode the one-hot load type into result and write strobes.
   always_comb begin
      byte_sel = 8'(rdata >> {addr, 3'b000});
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      result   = rdata;
      rf_we    = 4'b1111;
      unique case (1'b1)
         inst_load[LdLw]:  result = rdata;
         inst_load[LdLb]:  result = {{24{byte_sel[7]}}, byte_sel};
         inst_load[LdLbu]: result = {24'h0, byte_sel};
         inst_load[LdLh]:  result = {{16{half_sel[15]}}, half_sel};
         inst_load[LdLhu]: result = {16'h0, half_sel};
         // Unaligned pair: WB merges the unwritten bytes with the old rt.
         inst_load[LdLwl]: begin
            result = rdata << {~addr, 3'b000};
            rf_we  = 4'b1111 << ~addr;
         end
         inst_load[LdLwr]: begin
            result = rdata >> {addr, 3'b000};
            rf_we  = 4'b1111 >> addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, waits for in-order data SRAM
// responses, discards responses of flushed loads and hands results to WB.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ES_TO_MS_BUS_WD = EsToMsBusWd,
   parameter int unsigned MS_TO_WS_BUS_WD = MsToWsBusWd
) (
   input logic         clk,
   input logic         resetn,
   mem_stage_if.master pipe
);

   logic                       ms_valid_q;
   logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
   resp_state_e                state_q;
   logic [1:0]                 drop_cnt_q, drop_cnt_d;
   logic [31:0]                rdata_buf_q;

   es_to_ms_t es, es_in;
   ms_to_ws_t ms_out;

   logic        need_data, usable_ok, data_got, ready_go, ms_allowin;
   logic        accept, accept_need, drop_inc, drop_dec;
   logic [31:0] ld_rdata, ld_result;
   logic [3:0]  ld_we;
   logic        unused_fields;

   assign es    = es_to_ms_t'(es_bus_q);
   assign es_in = es_to_ms_t'(pipe.es_to_ms_bus);

   assign unused_fields = ^{es.ld_extd_op, es_in};

   assign need_data = es.res_from_mem && !es.exc;
   // A response is ours only while waiting and with no stale responses pending.
   assign usable_ok = pipe.data_sram_data_ok && (drop_cnt_q == 2'd0) && (state_q == StWait);
   assign data_got  = (state_q == StHave) || usable_ok;
   assign ready_go  = !need_data || data_got;
   assign ms_allowin = !ms_valid_q || (ready_go && pipe.ws_allowin);

   assign accept      = pipe.es_to_ms_valid && ms_allowin;
   assign accept_need = accept && es_in.res_from_mem && !es_in.exc;

   assign drop_dec = pipe.data_sram_data_ok && (drop_cnt_q != 2'd0);
   // Flush orphans an outstanding request: one already waiting, or one issued now.
   assign drop_inc = pipe.flush && (((state_q == StWait) && !usable_ok) || accept_need);

   // Next drop count, saturating at both ends.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_inc && !drop_dec) begin
         if (drop_cnt_q != 2'd3) drop_cnt_d = drop_cnt_q + 2'd1;
      end else if (drop_dec && !drop_inc) begin
         drop_cnt_d = drop_cnt_q - 2'd1;
      end
   end

   // Stage register, response FSM, drop counter and held read data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid_q  <= 1'b0;
         es_bus_q    <= '0;
         state_q     <= StIdle;
         drop_cnt_q  <= 2'd0;
         rdata_buf_q <= 32'h0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         if (accept) es_bus_q <= pipe.es_to_ms_bus;
         if (usable_ok) rdata_buf_q <= pipe.data_sram_rdata;
         if (pipe.flush) begin
            ms_valid_q <= 1'b0;
            state_q    <= StIdle;
         end else if (ms_allowin) begin
            ms_valid_q <= pipe.es_to_ms_valid;
            state_q    <= accept_need ? StWait : StIdle;
         end else if (usable_ok) begin
            state_q <= StHave;
         end
      end
   end

   assert property (@(posedge clk) disable iff (!resetn) drop_cnt_q != 2'd3)
      else $fatal(1, "mem_stage: drop counter saturated");

   assign ld_rdata = (state_q == StHave) ? rdata_buf_q : pipe.data_sram_rdata;

   mem_stage_ld_select u_ld_select (
      .inst_load (es.inst_load),
      .addr      (es.alu_result[1:0]),
      .rdata     (ld_rdata),
      .result    (ld_result),
      .rf_we     (ld_we)
   );

   // Assemble the WB bus; exception fields pass straight through.
   always_comb begin
      ms_out              = '0;
      ms_out.bd           = es.bd;
      ms_out.exc          = es.exc;
      ms_out.exc_type     = es.exc_type;
      ms_out.badvaddr     = es.badvaddr;
      ms_out.eret_flush   = es.eret_flush;
      ms_out.cp0_wen      = es.cp0_wen;
      ms_out.res_from_cp0 = es.res_from_cp0;
      ms_out.cp0_addr     = es.cp0_addr;
      ms_out.dest         = es.dest;
      ms_out.pc           = es.pc;
      ms_out.final_result = need_data ? ld_result : es.alu_result;
      if (es.exc)         ms_out.rf_we = 4'b0000;
      else if (need_data) ms_out.rf_we = ld_we;
      else                ms_out.rf_we = {4{es.gr_we}};
   end

   assign pipe.ms_allowin     = ms_allowin;
   assign pipe.ms_to_ws_valid = ms_valid_q && ready_go;
   assign pipe.ms_to_ws_bus   = MS_TO_WS_BUS_WD'(ms_out);
   assign pipe.stall_ms_bus   = {{5{ms_valid_q & es.gr_we}}, es.dest};
   assign pipe.forward_ms_bus = {ms_valid_q && ready_go && !es.res_from_cp0, ms_out.final_result};
   assign pipe.ms_exc_eret    = ms_valid_q && (es.exc || es.eret_flush);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: byte extraction, WB back-pressure, flush drops, reset.
module tb_mem_stage;

   localparam logic [6:0] LW  = 7'b1000000;
   localparam logic [6:0] LB  = 7'b0100000;
   localparam logic [6:0] LBU = 7'b0010000;
   localparam logic [6:0] LH  = 7'b0001000;
   localparam logic [6:0] LHU = 7'b0000100;
   localparam logic [6:0] LWL = 7'b0000010;
   localparam logic [6:0] LWR = 7'b0000001;

   typedef struct {
      logic [6:0]  ld;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [31:0] res;
      logic [3:0]  we;
   } ld_vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_handoff = 0;
   int   h0;
   ld_vec_t vecs[13];

   mem_stage_if ifc ();

   mem_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .pipe   (ifc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (resetn && ifc.ms_to_ws_valid && ifc.ws_allowin) n_handoff++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // EXE->MEM word, fields MSB to LSB.
   function automatic logic [135:0] es_word(input logic [6:0] ld, input logic [31:0] alu,
                                            input logic [4:0] dest, input logic gr_we,
                                            input logic exc, input logic [7:0] exc_type,
                                            input logic eret, input logic res_cp0,
                                            input logic bd, input logic [31:0] badv,
                                            input logic [31:0] pc);
      return {badv, bd, exc, exc_type, eret, 1'b0, res_cp0, 8'h0c,
              |ld, ld, 5'h00, gr_we, dest, alu, pc};
   endfunction

   function automatic logic [135:0] ld_word(input logic [6:0] ld, input logic [31:0] addr);
      return es_word(ld, addr, 5'd8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'hbfc0_0100);
   endfunction

   function automatic logic [31:0] res_of(input logic [125:0] b);
      return b[63:32];
   endfunction

   function automatic logic [3:0] we_of(input logic [125:0] b);
      return b[72:69];
   endfunction

   task automatic do_load(input int i);
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(vecs[i].ld, vecs[i].addr);
      #1 chk($sformatf("ld%0d_allowin", i), 64'(ifc.ms_allowin), 64'd1);
      tick();
      ifc.es_to_ms_valid    = 1'b0;
      ifc.data_sram_data_ok = 1'b1;
      ifc.data_sram_rdata   = vecs[i].rdata;
      #1;
      chk($sformatf("ld%0d_valid", i), 64'(ifc.ms_to_ws_valid), 64'd1);
      chk($sformatf("ld%0d_res", i), 64'(res_of(ifc.ms_to_ws_bus)), 64'(vecs[i].res));
      chk($sformatf("ld%0d_we", i), 64'(we_of(ifc.ms_to_ws_bus)), 64'(vecs[i].we));
      tick();
      ifc.data_sram_data_ok = 1'b0;
      #1 chk($sformatf("ld%0d_gone", i), 64'(ifc.ms_to_ws_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{LBU, 32'h1003, 32'h80FF1234, 32'h00000080, 4'hF};
      vecs[1]  = '{LWL, 32'h2001, 32'hAABBCCDD, 32'hCCDD0000, 4'hC};
      vecs[2]  = '{LWR, 32'h2002, 32'hAABBCCDD, 32'h0000AABB, 4'h3};
      vecs[3]  = '{LB,  32'h1002, 32'h80FF1234, 32'hFFFFFFFF, 4'hF};
      vecs[4]  = '{LB,  32'h1003, 32'h80FF1234, 32'hFFFFFF80, 4'hF};
      vecs[5]  = '{LH,  32'h1002, 32'h80FF1234, 32'hFFFF80FF, 4'hF};
      vecs[6]  = '{LHU, 32'h1000, 32'h80FF1234, 32'h00001234, 4'hF};
      vecs[7]  = '{LW,  32'h1000, 32'h80FF1234, 32'h80FF1234, 4'hF};
      vecs[8]  = '{LWL, 32'h2000, 32'hAABBCCDD, 32'hDD000000, 4'h8};
      vecs[9]  = '{LWR, 32'h2003, 32'hAABBCCDD, 32'h000000AA, 4'h1};
      vecs[10] = '{LBU, 32'h1001, 32'h80FF1234, 32'h00000012, 4'hF};
      vecs[11] = '{LH,  32'h1000, 32'h7FFF8001, 32'hFFFF8001, 4'hF};
      vecs[12] = '{LHU, 32'h1002, 32'h7FFF8001, 32'h00007FFF, 4'hF};

      ifc.flush             = 1'b0;
      ifc.ws_allowin        = 1'b1;
      ifc.es_to_ms_valid    = 1'b0;
      ifc.es_to_ms_bus      = '0;
      ifc.data_sram_data_ok = 1'b0;
      ifc.data_sram_rdata   = 32'h0;

      // Reset state.
      tick();
      tick();
      chk("rst_allowin", 64'(ifc.ms_allowin), 64'd1);
      chk("rst_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      chk("rst_stall", 64'(ifc.stall_ms_bus), 64'd0);
      chk("rst_fwd_v", 64'(ifc.forward_ms_bus[32]), 64'd0);
      chk("rst_exc", 64'(ifc.ms_exc_eret), 64'd0);
      resetn = 1'b1;

      // Plain ALU instruction, one cycle in MEM.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus = es_word(7'h0, 32'h12345678, 5'd3, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0,
                                 1'b0, 32'h0, 32'h0000_0100);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      #1;
      chk("alu_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
      chk("alu_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'h12345678);
      chk("alu_we", 64'(we_of(ifc.ms_to_ws_bus)), 64'hF);
      chk("alu_pc", 64'(ifc.ms_to_ws_bus[31:0]), 64'h100);
      chk("alu_fwd", 64'(ifc.forward_ms_bus), {31'h0, 1'b1, 32'h12345678});
      chk("alu_stall", 64'(ifc.stall_ms_bus), 64'h3E3);
      tick();
      chk("alu_gone", 64'(ifc.ms_to_ws_valid), 64'd0);

      // No register write.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus = es_word(7'h0, 32'h55, 5'd7, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0,
                                 1'b0, 32'h0, 32'h104);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      #1;
      chk("nowe_we", 64'(we_of(ifc.ms_to_ws_bus)), 64'h0);
      chk("nowe_stall", 64'(ifc.stall_ms_bus), 64'h007);
      tick();

      // Load extraction table, data_ok in the first WAIT cycle.
      for (int i = 0; i < 13; i++) do_load(i);

      // Slow response with WB back-pressure.
      h0 = n_handoff;
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h3000);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      ifc.ws_allowin     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("slow_wait_allowin", 64'(ifc.ms_allowin), 64'd0);
         chk("slow_wait_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
         tick();
      end
      ifc.data_sram_data_ok = 1'b1;
      ifc.data_sram_rdata   = 32'hDEADBEEF;
      #1;
      chk("slow_ok_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
      chk("slow_ok_allowin", 64'(ifc.ms_allowin), 64'd0);
      chk("slow_ok_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'hDEADBEEF);
      tick();
      ifc.data_sram_data_ok = 1'b0;
      ifc.data_sram_rdata   = 32'h0BAD0BAD;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("slow_hold_allowin", 64'(ifc.ms_allowin), 64'd0);
         chk("slow_hold_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
         chk("slow_hold_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'hDEADBEEF);
         tick();
      end
      ifc.ws_allowin = 1'b1;
      #1;
      chk("slow_go_allowin", 64'(ifc.ms_allowin), 64'd1);
      chk("slow_go_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'hDEADBEEF);
      tick();
      chk("slow_gone", 64'(ifc.ms_to_ws_valid), 64'd0);
      chk("slow_handoffs", 64'(n_handoff - h0), 64'd1);

      // Flush while waiting, then a new load; the first response belongs to the dead one.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h4000);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      ifc.flush          = 1'b1;
      tick();
      ifc.flush = 1'b0;
      #1;
      chk("fw_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      chk("fw_allowin", 64'(ifc.ms_allowin), 64'd1);
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h4004);
      tick();
      ifc.es_to_ms_valid    = 1'b0;
      ifc.data_sram_data_ok = 1'b1;
      ifc.data_sram_rdata   = 32'h1111;
      #1;
      chk("fw_drop_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      chk("fw_drop_allowin", 64'(ifc.ms_allowin), 64'd0);
      tick();
      ifc.data_sram_rdata = 32'h2222;
      #1;
      chk("fw_take_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
      chk("fw_take_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'h2222);
      tick();
      ifc.data_sram_data_ok = 1'b0;
      #1 chk("fw_gone", 64'(ifc.ms_to_ws_valid), 64'd0);

      // Flush on the accept cycle of a load.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h5000);
      ifc.flush          = 1'b1;
      tick();
      ifc.es_to_ms_valid = 1'b0;
      ifc.flush          = 1'b0;
      #1;
      chk("fa_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      chk("fa_allowin", 64'(ifc.ms_allowin), 64'd1);
      tick();
      ifc.data_sram_data_ok = 1'b1;
      ifc.data_sram_rdata   = 32'h3333;
      #1 chk("fa_drop_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      tick();
      ifc.data_sram_data_ok = 1'b0;
      #1 chk("fa_after_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h5004);
      tick();
      ifc.es_to_ms_valid    = 1'b0;
      ifc.data_sram_data_ok = 1'b1;
      ifc.data_sram_rdata   = 32'h4444;
      #1;
      chk("fa_next_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
      chk("fa_next_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'h4444);
      tick();
      ifc.data_sram_data_ok = 1'b0;

      // Reset while waiting.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h6000);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      #1 chk("rw_wait_allowin", 64'(ifc.ms_allowin), 64'd0);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #1;
      chk("rw_allowin", 64'(ifc.ms_allowin), 64'd1);
      chk("rw_valid", 64'(ifc.ms_to_ws_valid), 64'd0);
      chk("rw_stall", 64'(ifc.stall_ms_bus), 64'd0);
      chk("rw_fwd_v", 64'(ifc.forward_ms_bus[32]), 64'd0);
      chk("rw_exc", 64'(ifc.ms_exc_eret), 64'd0);
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus   = ld_word(LW, 32'h6004);
      tick();
      ifc.es_to_ms_valid    = 1'b0;
      ifc.data_sram_data_ok = 1'b1;
      ifc.data_sram_rdata   = 32'h5555;
      #1;
      chk("rw_next_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
      chk("rw_next_res", 64'(res_of(ifc.ms_to_ws_bus)), 64'h5555);
      tick();
      ifc.data_sram_data_ok = 1'b0;

      // Excepting load: no data wait, no write, fields pass through.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus = es_word(LW, 32'h7001, 5'd2, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0,
                                 1'b1, 32'h7001, 32'h200);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      #1;
      chk("exc_valid", 64'(ifc.ms_to_ws_valid), 64'd1);
      chk("exc_we", 64'(we_of(ifc.ms_to_ws_bus)), 64'h0);
      chk("exc_notify", 64'(ifc.ms_exc_eret), 64'd1);
      chk("exc_bit", 64'(ifc.ms_to_ws_bus[124]), 64'd1);
      chk("exc_type", 64'(ifc.ms_to_ws_bus[123:116]), 64'h04);
      chk("exc_badv", 64'(ifc.ms_to_ws_bus[115:84]), 64'h7001);
      chk("exc_bd", 64'(ifc.ms_to_ws_bus[125]), 64'd1);
      tick();

      // ERET reading CP0: notify set, no forwarding.
      ifc.es_to_ms_valid = 1'b1;
      ifc.es_to_ms_bus = es_word(7'h0, 32'h0, 5'd4, 1'b1, 1'b0, 8'h0, 1'b1, 1'b1,
                                 1'b0, 32'h0, 32'h204);
      tick();
      ifc.es_to_ms_valid = 1'b0;
      #1;
      chk("eret_notify", 64'(ifc.ms_exc_eret), 64'd1);
      chk("eret_fwd_v", 64'(ifc.forward_ms_bus[32]), 64'd0);
      chk("eret_bit", 64'(ifc.ms_to_ws_bus[83]), 64'd1);
      chk("eret_cp0", 64'(ifc.ms_to_ws_bus[81]), 64'd1);
      tick();
      chk("end_idle_exc", 64'(ifc.ms_exc_eret), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the five-stage MIPS core, between EXE and WB. It receives the EXE→MEM bus. It waits for load data on a variable-latency data-SRAM response channel and extracts or extends the addressed bytes. It then hands a result plus per-byte register write strobes to WB. It also discards responses belonging to loads cancelled by an exception or ERET flush, and drives the MEM-stage stall, forward and exception-notify buses.

## Interface
- `ES_TO_MS_BUS_WD`, default 136: EXE→MEM bus width (shared constant).
- `MS_TO_WS_BUS_WD`, default 126: MEM→WB bus width (shared constant).
- `clk`  in  1  : the only clock.
- `resetn`  in  1  : synchronous, active-low reset.
- `flush`  in  1  : exception/ERET flush from WB.
- `ws_allowin`  in  1  : WB can accept.
- `ms_allowin`  out  1  : MEM can accept.
- `es_to_ms_valid`  in  1  : EXE bus valid.
- `es_to_ms_bus`  in  136 : packed fields, MSB→LSB:
  - badvaddr[32], bd, exc, exc_type[8], eret_flush, cp0_wen, res_from_cp0, cp0_addr[8]
  - res_from_mem, inst_load[7] one-hot {lw,lb,lbu,lh,lhu,lwl,lwr}, ld_extd_op[5]
  - gr_we, dest[5], alu_result[32], pc[32]
- `data_sram_data_ok`  in  1  : one-cycle pulse, read data valid.
- `data_sram_rdata`  in  32 : read data, valid with data_ok.
- `ms_to_ws_valid`  out  1.
- `ms_to_ws_bus`  out  126 : packed fields, MSB→LSB: bd, exc, exc_type[8], badvaddr[32], eret_flush, cp0_wen, res_from_cp0, cp0_addr[8], rf_we[4], dest[5], final_result[32], pc[32].
- `stall_ms_bus`  out  10 : {5{ms_valid&gr_we}}, dest.
- `forward_ms_bus`  out  33 : {fwd_valid, final_result}.
- `ms_exc_eret`  out  1  : drives one bit of EXE's `es_exc_eret_bus`.

## Operation
- Request contract: EXE issues a load request only on the cycle `es_to_ms_valid && ms_allowin`, and only when res_from_mem=1 and exc=0 (need_data). Responses return in order with latency ≥1 cycle.
- Pipeline control:
  - `ready_go = !need_data || data_got`.
  - `ms_allowin = !ms_valid || ready_go && ws_allowin`.
  - `ms_to_ws_valid = ms_valid && ready_go`.
  - Bus register loads on `es_to_ms_valid && ms_allowin`.
- Response FSM (2 bits plus a 2-bit `drop_cnt`):
  - IDLE: MEM is not waiting for data.
  - WAIT: MEM holds a need_data instruction and no data has arrived.
  - HAVE: data is latched in `rdata_buf`, which holds it while WB stalls.
  - IDLE→WAIT on accepting a need_data instruction.
  - WAIT→HAVE on data_ok with drop_cnt=0.
  - HAVE→IDLE (or →WAIT) when MEM hands off and accepts the next instruction.
- Drop handling:
  - data_ok with drop_cnt>0: decrement drop_cnt, discard data, FSM unchanged.
  - flush in WAIT without a usable data_ok that cycle: drop_cnt+1.
  - flush on the same cycle a need_data instruction is accepted: drop_cnt+1. The flush wins, so ms_valid←0.
  - All flushes clear ms_valid and return the FSM to IDLE.
  - drop_cnt saturating at 3 is a fatal assertion.
- Load extraction, using a = alu_result[1:0], little-endian, d = rdata:
  - lw: d, rf_we 1111.
  - lb/lbu: byte a, sign-/zero-extended, 1111.
  - lh/lhu: half a[1], sign-/zero-extended, 1111.
  - lwl: d<<8·(3−a); rf_we 1000/1100/1110/1111 for a=0..3.
  - lwr: d>>8·a; rf_we 1111/0111/0011/0001. WB merges lwl/lwr with the old rt.
- Non-loads: final_result = alu_result, rf_we = {4{gr_we}}. When exc=1, rf_we = 0000.
- `fwd_valid = ms_valid && ready_go && !res_from_cp0`.
- `ms_exc_eret = ms_valid && (exc || eret_flush)`.
- MEM adds no exceptions of its own; all exception fields pass through.

## Timing
- Reset (resetn=0 at a clock edge): ms_valid=0, FSM=IDLE, drop_cnt=0, rdata_buf=0. Outputs: ms_allowin=1, ms_to_ws_valid=0, forward/stall valid bits 0, ms_exc_eret=0.
- Non-load: one cycle in MEM when WB allows.
- Load:
  - When data_ok arrives in the first cycle of WAIT, the result is combinationally available and `ms_to_ws_valid` asserts the same cycle.
  - Otherwise the stage stalls until data_ok.
- While WB stalls in HAVE, the output is stable and taken from `rdata_buf`.

## Structure
- Shared `mycpu.h`: `ES_TO_MS_BUS_WD`, `MS_TO_WS_BUS_WD`, `STALL_BUS_WD`, `FORWARD_BUS_WD`, FSM state encodings, inst_load bit indices.
- One sub-module, `ld_select`: combinational {inst_load, a, rdata} → {result, rf_we}.

## Test plan
- lbu, addr 0x..3, rdata 0x80FF1234, data_ok 1 cycle after issue → final_result 0x00000080, rf_we 1111, handoff the same cycle.
- lwl, a=1, rdata 0xAABBCCDD → result 0xCCDD0000, rf_we 1100. lwr, a=2 → 0x0000AABB, rf_we 0011.
- Load with data_ok after 4 cycles while ws_allowin=0 for 3 further cycles → ms_allowin=0 throughout; rdata_buf holds; exactly one handoff.
- Flush in WAIT, then a new lw accepted, then two data_ok (0x1111, 0x2222) → the first is dropped (drop_cnt 1→0); WB gets 0x2222.
- Flush on the same cycle as accepting a load, data_ok 2 cycles later → dropped; ms_to_ws_valid stays 0.
- resetn=0 mid-WAIT → all reset values next cycle; drop_cnt=0.
